// File: rtl/simon_sound_pkg.sv
// Shared definitions for the Simon audio back end: FSM state codes, note
// half periods and the win/lose/high-score jingle tables.
package simon_sound_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_TONE = 3'd1;
    localparam state_t ST_WIN  = 3'd2;
    localparam state_t ST_LOSE = 3'd3;
    localparam state_t ST_HS   = 3'd4;

    // Note codes 0..3 are the four button tones; 4 is the lose buzz.
    typedef logic [2:0] note_t;

    localparam note_t NOTE_BUZZ = 3'd4;

    // Half periods in oscillator ticks.
    localparam int unsigned HP_TONE0 = 1205;
    localparam int unsigned HP_TONE1 = 1613;
    localparam int unsigned HP_TONE2 = 1984;
    localparam int unsigned HP_TONE3 = 2392;
    localparam int unsigned HP_BUZZ  = 11905;

    // Jingle tables: element [i] is the note of step i.
    localparam note_t [3:0] WIN_NOTES = {3'd3, 3'd2, 3'd1, 3'd0};
    localparam note_t [3:0] HS_NOTES  = {3'd0, 3'd3, 3'd0, 3'd3};
    localparam note_t       LOSE_NOTE = NOTE_BUZZ;

    localparam logic [2:0] WIN_BEATS  = 3'd2;
    localparam logic [2:0] LOSE_BEATS = 3'd6;
    localparam logic [2:0] HS_BEATS   = 3'd1;

    localparam int WIN_STEPS  = 4;
    localparam int LOSE_STEPS = 1;
    localparam int HS_STEPS   = 4;

    function automatic int unsigned note_hp(input note_t n);
        case (n)
            3'd0:    return HP_TONE0;
            3'd1:    return HP_TONE1;
            3'd2:    return HP_TONE2;
            3'd3:    return HP_TONE3;
            default: return HP_BUZZ;
        endcase
    endfunction

    function automatic note_t jingle_note(input state_t st, input logic [1:0] idx);
        case (st)
            ST_WIN:  return WIN_NOTES[idx];
            ST_HS:   return HS_NOTES[idx];
            ST_LOSE: return LOSE_NOTE;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] step_beats(input state_t st);
        case (st)
            ST_WIN:  return WIN_BEATS;
            ST_LOSE: return LOSE_BEATS;
            default: return HS_BEATS;
        endcase
    endfunction

    function automatic logic [1:0] last_step(input state_t st);
        case (st)
            ST_WIN:  return 2'(WIN_STEPS - 1);
            ST_LOSE: return 2'(LOSE_STEPS - 1);
            default: return 2'(HS_STEPS - 1);
        endcase
    endfunction

    // Higher rank preempts lower; idle and steady tone rank lowest.
    function automatic logic [1:0] event_rank(input state_t st);
        case (st)
            ST_LOSE: return 2'd3;
            ST_WIN:  return 2'd2;
            ST_HS:   return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/tone_osc.sv
// Square-wave oscillator: prescaler tick, half-period counter and toggle flop.
module tone_osc #(
    parameter int PRESCALE = 50,
    parameter int HP_W     = 14
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            restart,
    input  logic [HP_W-1:0] hp,
    output logic            wave
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]   pre;
    logic [HP_W-1:0] hp_cnt;
    logic            tick;

    assign tick = (pre == PW'(PRESCALE - 1));

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre    <= '0;
            hp_cnt <= '0;
            wave   <= 1'b0;
        end else if (!run) begin
            pre    <= '0;
            hp_cnt <= '0;
            wave   <= 1'b0;
        end else if (restart) begin
            // New note or step: phase restarts, output level is kept.
            pre    <= '0;
            hp_cnt <= '0;
        end else begin
            pre <= tick ? '0 : pre + PW'(1);
            if (tick) begin
                if (hp_cnt == hp - HP_W'(1)) begin
                    hp_cnt <= '0;
                    wave   <= ~wave;
                end else begin
                    hp_cnt <= hp_cnt + HP_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/simon_sound.sv
// Simon audio back end: button tones and event jingles onto one speaker pin,
// with event priority lose > win > hs and beat-paced jingle steps.
module simon_sound
    import simon_sound_pkg::*;
#(
    parameter int PRESCALE = 50,
    parameter int HP_W     = 14
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] tone,
    input  logic       tone_ena,
    input  logic       win,
    input  logic       lose,
    input  logic       hs,
    input  logic       beat,
    input  logic       mute,
    output logic       spk,
    output logic       busy
);

    state_t          state, state_nxt, ev_state;
    logic [1:0]      step, step_nxt;
    logic [2:0]      beat_cnt, beat_cnt_nxt;
    note_t           note, note_nxt;
    logic            osc_run, osc_restart, wave;
    logic [HP_W-1:0] hp;

    always_comb begin
        if (lose)      ev_state = ST_LOSE;
        else if (win)  ev_state = ST_WIN;
        else if (hs)   ev_state = ST_HS;
        else           ev_state = ST_IDLE;
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        step_nxt     = step;
        beat_cnt_nxt = beat_cnt;
        if (event_rank(ev_state) > event_rank(state)) begin
            state_nxt    = ev_state;
            step_nxt     = '0;
            beat_cnt_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: if (tone_ena)  state_nxt = ST_TONE;
                ST_TONE: if (!tone_ena) state_nxt = ST_IDLE;
                default: begin
                    if (beat) begin
                        if (beat_cnt == step_beats(state) - 3'd1) begin
                            beat_cnt_nxt = '0;
                            if (step == last_step(state)) begin
                                state_nxt = tone_ena ? ST_TONE : ST_IDLE;
                                step_nxt  = '0;
                            end else begin
                                step_nxt = step + 2'd1;
                            end
                        end else begin
                            beat_cnt_nxt = beat_cnt + 3'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        case (state_nxt)
            ST_IDLE: note_nxt = note;
            ST_TONE: note_nxt = {1'b0, tone};
            default: note_nxt = jingle_note(state_nxt, step_nxt);
        endcase
    end

    // Oscillator control follows the next state so it switches on the same
    // edge as the FSM.
    assign osc_run     = (state_nxt != ST_IDLE);
    assign osc_restart = (state_nxt != state) || (note_nxt != note) || (step_nxt != step);
    assign hp          = HP_W'(note_hp(note));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            step     <= '0;
            beat_cnt <= '0;
            note     <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            step     <= step_nxt;
            beat_cnt <= beat_cnt_nxt;
            note     <= note_nxt;
            busy     <= (event_rank(state_nxt) != 2'd0);
        end
    end

    tone_osc #(
        .PRESCALE (PRESCALE),
        .HP_W     (HP_W)
    ) u_osc (
        .clk     (clk),
        .rst     (rst),
        .run     (osc_run),
        .restart (osc_restart),
        .hp      (hp),
        .wave    (wave)
    );

    assign spk = wave & ~mute;

endmodule

// File: doc/simon_sound.md
# simon_sound

Audio back end for the Simon game. It receives the controller's button-tone output and game-event pulses. It plays the matching square-wave tone or a fixed jingle for win, lose and high score, and drives a single speaker pin. It sits downstream of the controller, in parallel with the LED decode, and mirrors the light/event interface onto sound.

## Interface
Parameters:
- PRESCALE, 50: clk cycles per oscillator tick (1 MHz tick at 50 MHz clk).
- HP_W, 14: width of the half-period counter, in ticks.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset. One clock domain only.
- tone  in  2  button code from the controller (0..3).
- tone_ena  in  1  button tone requested; level, sampled every cycle.
- win  in  1  one-cycle pulse: round won.
- lose  in  1  one-cycle pulse: game lost.
- hs  in  1  one-cycle pulse: new high score.
- beat  in  1  one-cycle timing strobe that paces jingle steps.
- mute  in  1  level; forces spk low without affecting state.
- spk  out  1  speaker square wave.
- busy  out  1  high while a jingle is playing.

## Operation
- Half periods, in ticks, live in the package:
  - tone 0: 1205
  - tone 1: 1613
  - tone 2: 1984
  - tone 3: 2392
  - buzz: 11905
- States: IDLE, TONE, WIN, LOSE, HS.
- IDLE:
  - spk=0; prescaler and half-period counter held at 0.
  - tone_ena=1 goes to TONE.
  - An event pulse goes to its jingle state.
- TONE:
  - Plays the HP of the current `tone` value.
  - tone_ena=0 returns to IDLE next cycle, with spk forced to 0.
  - If `tone` changes mid-note, the half-period counter restarts at 0 and spk keeps its current level.
- WIN: steps through tones 0,1,2,3, two beats each (8 beats), then returns to IDLE.
- LOSE: buzz for 6 beats, then returns to IDLE.
- HS: steps through tones 3,0,3,0, one beat each (4 beats), then returns to IDLE.
- Event priority is lose > win > hs.
  - Simultaneous pulses: the highest-priority event is taken; the others are dropped.
  - During a jingle, only a strictly higher-priority event preempts it. The step counter and oscillator restart on preemption. Equal or lower events are ignored.
  - tone_ena is ignored during a jingle. When the jingle ends, if tone_ena=1 the block enters TONE, otherwise IDLE.
- Jingle step changes reset the half-period counter; spk keeps its level.
- busy=1 in WIN, LOSE and HS; 0 otherwise.
- mute=1 forces spk=0 combinationally after the toggle flop; the internal toggle state keeps running.
- Reset values:
  - state IDLE, spk=0, busy=0.
  - all counters 0.
  - Reset mid-jingle aborts it immediately.

## Timing
- Prescaler counts 0..PRESCALE-1 and emits a tick on the last count. It is cleared on entry from IDLE and on tone or step changes.
- Half-period counter:
  - Increments on each tick.
  - On the tick where it equals HP-1, spk toggles and the counter wraps to 0.
- Onset latency: an event or tone_ena sampled at edge k gives the first spk rise at edge k + PRESCALE·HP.
- Beat counting: beats count only from the cycle after an event is accepted. A beat coincident with the accepting edge is not counted.
- The final beat of a jingle moves the state to IDLE or TONE at that same edge, and busy falls on that edge.
- Outputs spk and busy are registered, apart from the mute gating of spk. The mute path is the only combinational input→output path.

## Structure
- simon_sound_pkg holds:
  - the state enum;
  - the HP constants for the four tones and the buzz;
  - the jingle tables: step tone and beats per step for WIN, LOSE and HS;
  - the step-count constants.
- Sub-module tone_osc contains the prescaler, the half-period counter and the toggle flop.
  - Inputs: clk, rst, run, restart, hp.
  - Output: wave.
- simon_sound holds the FSM, the beat/step counters and the priority logic.

## Test plan
All scenarios run with PRESCALE=2 to keep simulation short.
- Reset state: assert rst mid-TONE → spk=0 and busy=0 immediately; after release, tone_ena=0 gives spk=0 indefinitely.
- Steady tone: tone=0, tone_ena=1 at edge 10 → spk rises at edge 10+2·1205=2420 and falls at 4830. Drop tone_ena → spk=0 next cycle.
- Win jingle: pulse win, with beat every 100 cycles.
  - busy=1 for exactly 8 beats; the measured half period steps 1205→1613→1984→2392 every 2 beats.
  - busy falls on the 8th counted beat.
- Preemption: win at t0, then lose 3 beats later → jingle switches to buzz (half period 2·11905 cycles), busy stays high for 6 more beats. An hs pulse during LOSE is ignored.
- Simultaneous events: win, lose and hs pulse in the same cycle → LOSE plays; no WIN or HS follows.
- Mute and tone change:
  - mute=1 during TONE → spk=0 while the internal phase advances; releasing mute resumes on the unchanged schedule.
  - tone 1→2 mid-note → next toggle comes 2·1984 cycles after the change.
